// File: rtl/decode_queue.sv
//==============================================================================
// Module : decode_queue
// Desc   : DEPTH-entry instruction FIFO with a registered MIPS decode stage.
//          Optional illegal-opcode check: define DECODE_ILLEGAL_CHK_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_instr_i,
  input  logic [PC_W-1:0]          in_pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [PC_W-1:0]          pc_o,
  output logic [5:0]               op_o,
  output logic [5:0]               funct_o,
  output logic [4:0]               rs_o,
  output logic [4:0]               rt_o,
  output logic [4:0]               rd_o,
  output logic [4:0]               shamt_o,
  output logic [25:0]              target_o,
  output logic [31:0]              imm_o,
  output logic                     is_r_o,
  output logic                     is_i_o,
  output logic                     is_j_o,
  output logic                     use_link_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     illegal_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);

  logic [31:0]     r_mem_instr [DEPTH];
  logic [PC_W-1:0] r_mem_pc    [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  logic            r_out_valid;
  logic [PC_W-1:0] r_pc;
  logic [5:0]      r_op;
  logic [5:0]      r_funct;
  logic [4:0]      r_rs;
  logic [4:0]      r_rt;
  logic [4:0]      r_rd;
  logic [4:0]      r_shamt;
  logic [25:0]     r_target;
  logic [31:0]     r_imm;
  logic            r_is_r;
  logic            r_is_i;
  logic            r_is_j;
  logic            r_use_link;

  logic            w_in_xfer;
  logic            w_load;
  logic            w_empty;
  logic            w_pop;
  logic            w_bypass;
  logic            w_push;
  logic [31:0]     w_src_instr;
  logic [PC_W-1:0] w_src_pc;

  logic [5:0]      w_op;
  logic [5:0]      w_funct;
  logic            w_is_r;
  logic            w_is_j;
  logic            w_zext;
  logic [31:0]     w_imm;
  logic            w_link;

  // A flush cycle never accepts the incoming word even when ready is high.
  assign in_ready_o  = (r_count < c_DEPTH_CNT);
  assign w_in_xfer   = in_valid_i && in_ready_o && !flush_i;
  assign w_load      = !r_out_valid || out_ready_i;
  assign w_empty     = (r_count == '0);
  assign w_pop       = w_load && !w_empty;
  assign w_bypass    = w_load && w_empty && w_in_xfer;
  assign w_push      = w_in_xfer && !w_bypass;
  assign w_src_instr = w_pop ? r_mem_instr[r_rptr] : in_instr_i;
  assign w_src_pc    = w_pop ? r_mem_pc[r_rptr]    : in_pc_i;

  always_comb begin
    w_op    = w_src_instr[31:26];
    w_funct = w_src_instr[5:0];
    w_is_r  = (w_op == 6'h00);
    w_is_j  = (w_op == 6'h02) || (w_op == 6'h03);
    w_zext  = (w_op == 6'h0C) || (w_op == 6'h0D) || (w_op == 6'h0E);
    w_imm   = w_zext ? {16'h0000, w_src_instr[15:0]}
                     : {{16{w_src_instr[15]}}, w_src_instr[15:0]};
    w_link  = ((w_op == 6'h01) && (w_src_instr[20:17] == 4'b1000)) // rt 0x10/0x11
           || (w_is_r && (w_funct == 6'h09))
           || (w_op == 6'h03);
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem_instr[r_wptr] <= in_instr_i;
      r_mem_pc[r_wptr]    <= in_pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_pc        <= '0;
      r_op        <= '0;
      r_funct     <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_shamt     <= '0;
      r_target    <= '0;
      r_imm       <= '0;
      r_is_r      <= 1'b0;
      r_is_i      <= 1'b0;
      r_is_j      <= 1'b0;
      r_use_link  <= 1'b0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= w_pop || w_bypass;
      if (w_pop || w_bypass) begin
        r_pc       <= w_src_pc;
        r_op       <= w_op;
        r_funct    <= w_funct;
        r_rs       <= w_src_instr[25:21];
        r_rt       <= w_src_instr[20:16];
        r_rd       <= w_src_instr[15:11];
        r_shamt    <= w_src_instr[10:6];
        r_target   <= w_src_instr[25:0];
        r_imm      <= w_imm;
        r_is_r     <= w_is_r;
        r_is_i     <= !w_is_r && !w_is_j;
        r_is_j     <= w_is_j;
        r_use_link <= w_link;
      end
    end
  end

`ifdef DECODE_ILLEGAL_CHK_EN
  logic w_illegal;
  logic r_illegal;

  // Implemented set: MIPS-I integer ALU, branch, jump and load/store opcodes.
  always_comb begin
    w_illegal = 1'b1;
    case (w_op)
      6'h00: begin
        case (w_funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
          6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: w_illegal = 1'b0;
          default:      w_illegal = 1'b1;
        endcase
      end
      6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B:
        w_illegal = 1'b0;
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_illegal <= 1'b0;
    else if (!flush_i && w_load && (w_pop || w_bypass))
      r_illegal <= w_illegal;
  end

  assign illegal_o = r_illegal;
`else
  assign illegal_o = 1'b0;
`endif

  assign out_valid_o = r_out_valid;
  assign pc_o        = r_pc;
  assign op_o        = r_op;
  assign funct_o     = r_funct;
  assign rs_o        = r_rs;
  assign rt_o        = r_rt;
  assign rd_o        = r_rd;
  assign shamt_o     = r_shamt;
  assign target_o    = r_target;
  assign imm_o       = r_imm;
  assign is_r_o      = r_is_r;
  assign is_i_o      = r_is_i;
  assign is_j_o      = r_is_j;
  assign use_link_o  = r_use_link;
  assign count_o     = r_count;

endmodule

`default_nettype wire
